// File: rtl/alu_pkg.sv
// Opcode encodings, FSM state encoding and small decode helpers for seq_alu.
package alu_pkg;

    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPW-1:0] OP_AND  = 5'b01010;
    localparam logic [OPW-1:0] OP_OR   = 5'b01011;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL    = 3'd1,
        S_DIV    = 3'd2,
        S_DIVFIX = 3'd3,
        S_DONE   = 3'd4
    } alu_state_e;

    // True for opcodes that complete on the accepting edge.
    function automatic logic is_single_op(input logic [OPW-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG,
            OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: is_single_op = 1'b1;
            default:                                 is_single_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed restoring divide engine.
// go loads operands; WIDTH steps follow. finish_c flags the last step cycle.
// For MUL, result_c is the product the last step produces; for DIV,
// result_c is the sign-corrected {remainder, quotient} once stepping ends.
module alu_muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               mode,      // 0: multiply, 1: divide
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               finish_c,
    output logic [2*WIDTH-1:0] result_c
);

    localparam int unsigned AW = WIDTH + 1;

    logic             mode_div;
    logic [SHW-1:0]   cnt;
    logic [AW-1:0]    acc;       // Booth accumulator / divide remainder
    logic [WIDTH-1:0] mq;        // Booth multiplier / divide quotient
    logic             q_m1;      // Booth appended bit
    logic [AW-1:0]    mcand;     // sign-extended multiplicand / zero-extended divisor
    logic             neg_q;
    logic             neg_r;

    logic [AW-1:0]    booth_sum;
    logic [AW-1:0]    mul_acc_n;
    logic [WIDTH-1:0] mul_mq_n;
    logic [AW-1:0]    div_shift;
    logic             div_fits;
    logic [AW-1:0]    div_acc_n;
    logic [WIDTH-1:0] div_mq_n;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    // Operand magnitudes for the divider; MIN maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        a_abs = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
        b_abs = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    end

    // One Booth step: add/sub multiplicand by {lsb, appended bit}, then arithmetic shift.
    always_comb begin
        case ({mq[0], q_m1})
            2'b01:   booth_sum = acc + mcand;
            2'b10:   booth_sum = acc - mcand;
            default: booth_sum = acc;
        endcase
        mul_acc_n = {booth_sum[AW-1], booth_sum[AW-1:1]};
        mul_mq_n  = {booth_sum[0], mq[WIDTH-1:1]};
    end

    // One restoring-division step on magnitudes.
    always_comb begin
        div_shift = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_fits  = (div_shift >= mcand);
        div_acc_n = div_fits ? (div_shift - mcand) : div_shift;
        div_mq_n  = {mq[WIDTH-2:0], div_fits};
    end

    // Sign correction: quotient negative on sign mismatch, remainder follows dividend.
    always_comb begin
        quo_fix = neg_q ? (WIDTH'(0) - mq) : mq;
        rem_fix = neg_r ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    end

    // Handshake and result selection toward the top-level FSM.
    always_comb begin
        finish_c = busy && (cnt == SHW'(WIDTH - 1));
        result_c = mode_div ? {rem_fix, quo_fix} : {mul_acc_n[WIDTH-1:0], mul_mq_n};
    end

    // Operand load on go, then one step per cycle for WIDTH cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            mode_div <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            q_m1     <= 1'b0;
            mcand    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else if (go) begin
            busy     <= 1'b1;
            mode_div <= mode;
            cnt      <= '0;
            acc      <= '0;
            q_m1     <= 1'b0;
            if (mode) begin
                mq    <= a_abs;
                mcand <= {1'b0, b_abs};
                neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r <= a[WIDTH-1];
            end else begin
                mq    <= a;
                mcand <= {b[WIDTH-1], b};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
            end
        end else if (busy) begin
            cnt <= cnt + SHW'(1);
            if (cnt == SHW'(WIDTH - 1)) begin
                busy <= 1'b0;
            end
            if (mode_div) begin
                acc <= div_acc_n;
                mq  <= div_mq_n;
            end else begin
                acc  <= mul_acc_n;
                mq   <= mul_mq_n;
                q_m1 <= mq[0];
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
// Result is a 2*WIDTH register {HI, LO} updated only when entering DONE.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [OPW-1:0]     opcode,
    input  logic [WIDTH-1:0]   ra,
    input  logic [WIDTH-1:0]   rb,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] rc,
    output logic               div_zero,
    output logic               illegal_op
);

    alu_state_e         state;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
    logic [WIDTH-1:0]   single_c;
    logic               md_go_c;
    logic               md_mode_c;
    logic               md_busy;
    logic               md_finish_c;
    logic [2*WIDTH-1:0] md_result_c;

    // Rotates via a doubled operand so amount 0 needs no special case.
    always_comb begin
        amt   = rb[SHW-1:0];
        rot_r = {ra, ra} >> amt;
        rot_l = {ra, ra} << amt;
    end

    // Single-cycle result, computed from the live inputs on the accepting edge.
    always_comb begin
        single_c = '0;
        case (opcode)
            OP_ADD:  single_c = ra + rb;
            OP_SUB:  single_c = ra - rb;
            OP_AND:  single_c = ra & rb;
            OP_OR:   single_c = ra | rb;
            OP_NOT:  single_c = ~ra;
            OP_NEG:  single_c = WIDTH'(0) - ra;
            OP_SHR:  single_c = ra >> amt;
            OP_SHRA: single_c = WIDTH'($signed(ra) >>> amt);
            OP_SHL:  single_c = ra << amt;
            OP_ROR:  single_c = rot_r[WIDTH-1:0];
            OP_ROL:  single_c = rot_l[2*WIDTH-1:WIDTH];
            default: single_c = '0;
        endcase
    end

    // Launch the iterative engine for MUL and for DIV with a nonzero divisor.
    always_comb begin
        md_mode_c = (opcode == OP_DIV);
        md_go_c   = (state == S_IDLE) && start &&
                    ((opcode == OP_MUL) || ((opcode == OP_DIV) && (rb != '0)));
    end

    alu_muldiv_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .go       (md_go_c),
        .mode     (md_mode_c),
        .a        (ra),
        .b        (rb),
        .busy     (md_busy),
        .finish_c (md_finish_c),
        .result_c (md_result_c)
    );

    // Control FSM with registered ready/done/flags and result register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rc         <= '0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
            ready      <= 1'b1;
        end else begin
            done       <= 1'b0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (is_single_op(opcode)) begin
                            rc    <= {{WIDTH{1'b0}}, single_c};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (opcode == OP_MUL) begin
                            state <= S_MUL;
                        end else if (opcode == OP_DIV) begin
                            if (rb == '0) begin
                                rc       <= {ra, {WIDTH{1'b1}}};
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            rc         <= '0;
                            illegal_op <= 1'b1;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    if (md_finish_c) begin
                        rc    <= md_result_c;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    if (md_finish_c) begin
                        state <= S_DIVFIX;
                    end
                end
                S_DIVFIX: begin
                    rc    <= md_result_c;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: expectations queued at issue, compared at done.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [4:0]    opcode;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic          ready;
    logic          done;
    logic [2*W-1:0] rc;
    logic          div_zero;
    logic          illegal_op;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [63:0] rc;
        logic        dz;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .ra         (ra),
        .rb         (rb),
        .ready      (ready),
        .done       (done),
        .rc         (rc),
        .div_zero   (div_zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally poke start while busy, then compare against the queued expectation.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] erc, input logic edz,
                          input logic eill, input int elat, input bit poke);
        logic [63:0] rc_before;
        int          edges;
        int          busy_bad;
        exp_t        e;
        @(negedge clk);
        rc_before = rc;
        sb.push_back('{tag, erc, edz, eill, elat});
        start  = 1'b1;
        opcode = op;
        ra     = a;
        rb     = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edges    = 1;
        busy_bad = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (poke) begin
                if (edges == 5) begin
                    start = 1'b1; opcode = OP_ADD; ra = 32'd1; rb = 32'd1;
                end else if (edges == 7) begin
                    start = 1'b0;
                end
            end
            if (rc !== rc_before || ready !== 1'b0 || done !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".done"},     64'(done), 64'd1);
        chk({e.tag, ".latency"},  64'(edges), 64'(e.lat));
        chk({e.tag, ".rc"},       rc, e.rc);
        chk({e.tag, ".div_zero"}, 64'(div_zero), 64'(e.dz));
        chk({e.tag, ".illegal"},  64'(illegal_op), 64'(e.ill));
        chk({e.tag, ".ready_lo"}, 64'(ready), 64'd0);
        chk({e.tag, ".busy"},     64'(busy_bad), 64'd0);
        @(posedge clk);
        #1;
        chk({e.tag, ".after"},    64'({done, ready, div_zero, illegal_op}), 64'(4'b0100));
        chk({e.tag, ".held"},     rc, e.rc);
    endtask

    initial begin
        int edges_seen;
        reset  = 1'b0;
        start  = 1'b0;
        opcode = '0;
        ra     = '0;
        rb     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.rc",    rc, 64'd0);
        chk("reset.flags", 64'({done, ready, div_zero, illegal_op}), 64'(4'b0100));
        @(negedge clk);
        reset = 1'b1;

        run_op("add",      OP_ADD,  32'd5,          32'd7,          64'h0000_0000_0000_000C, 1'b0, 1'b0, 1,  1'b0);
        run_op("add_wrap", OP_ADD,  32'hFFFF_FFFF,  32'd1,          64'h0,                   1'b0, 1'b0, 1,  1'b0);
        run_op("sub",      OP_SUB,  32'd3,          32'd5,          64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 1,  1'b0);
        run_op("neg",      OP_NEG,  32'd5,          32'h1234_5678,  64'h0000_0000_FFFF_FFFB, 1'b0, 1'b0, 1,  1'b0);
        run_op("not",      OP_NOT,  32'h0F0F_00FF,  32'hDEAD_BEEF,  64'h0000_0000_F0F0_FF00, 1'b0, 1'b0, 1,  1'b0);
        run_op("and",      OP_AND,  32'hFF00_FF00,  32'h0FF0_0FF0,  64'h0000_0000_0F00_0F00, 1'b0, 1'b0, 1,  1'b0);
        run_op("or",       OP_OR,   32'hFF00_0000,  32'h0000_00FF,  64'h0000_0000_FF00_00FF, 1'b0, 1'b0, 1,  1'b0);
        run_op("shl0",     OP_SHL,  32'hA5A5_A5A5,  32'd0,          64'h0000_0000_A5A5_A5A5, 1'b0, 1'b0, 1,  1'b0);
        run_op("shl",      OP_SHL,  32'h8000_0003,  32'd2,          64'h0000_0000_0000_000C, 1'b0, 1'b0, 1,  1'b0);
        run_op("shr",      OP_SHR,  32'h8000_0000,  32'd4,          64'h0000_0000_0800_0000, 1'b0, 1'b0, 1,  1'b0);
        run_op("ror",      OP_ROR,  32'd1,          32'd1,          64'h0000_0000_8000_0000, 1'b0, 1'b0, 1,  1'b0);
        run_op("shra",     OP_SHRA, 32'h8000_0000,  32'd4,          64'h0000_0000_F800_0000, 1'b0, 1'b0, 1,  1'b0);
        run_op("rol33",    OP_ROL,  32'h8000_0001,  32'd33,         64'h0000_0000_0000_0003, 1'b0, 1'b0, 1,  1'b0);
        run_op("illegal",  5'b11111, 32'd4,         32'd4,          64'h0,                   1'b0, 1'b1, 1,  1'b0);
        run_op("mul",      OP_MUL,  32'hFFFF_FFFD,  32'd7,          64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0, 33, 1'b1);
        run_op("mul_min",  OP_MUL,  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 1'b0, 1'b0, 33, 1'b0);
        run_op("mul_m1",   OP_MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 1'b0, 1'b0, 33, 1'b0);
        run_op("div",      OP_DIV,  32'hFFFF_FFEF,  32'd5,          64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b0, 34, 1'b0);
        run_op("div_min",  OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 1'b0, 1'b0, 34, 1'b0);
        run_op("div_negb", OP_DIV,  32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0, 34, 1'b0);
        run_op("div_zero", OP_DIV,  32'd9,          32'd0,          64'h0000_0009_FFFF_FFFF, 1'b1, 1'b0, 1,  1'b0);

        // Abort a DIV with reset partway through.
        @(negedge clk);
        start = 1'b1; opcode = OP_DIV; ra = 32'd100; rb = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort.rc",    rc, 64'd0);
        chk("abort.flags", 64'({done, ready}), 64'(2'b01));
        edges_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) edges_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) edges_seen++;
        end
        chk("abort.nodone", 64'(edges_seen), 64'd0);
        run_op("add_post", OP_ADD, 32'd20, 32'd22, 64'h0000_0000_0000_002A, 1'b0, 1'b0, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
